// File: rtl/jtdd2_dwnld_pkg.sv
// Shared download constants: region map, SDRAM bases, byte-lane masks and queue entry layout.
package jtdd2_dwnld_pkg;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MASK_W  = 2;
  localparam int unsigned PROM_AW = 9;

  // ioctl byte-address region starts
  localparam logic [21:0] SCRZW_ADDR = 22'h090000;
  localparam logic [21:0] SCRXY_ADDR = 22'h0B0000;
  localparam logic [21:0] OBJWZ_ADDR = 22'h0D0000;
  localparam logic [21:0] OBJXY_ADDR = 22'h130000;
  localparam logic [21:0] PROM_ADDR  = 22'h190000;
  localparam logic [21:0] PROM_END   = 22'h190200;

  // SDRAM word bases for the interleaved graphics ROMs
  localparam logic [21:0] SCR_SDRAM = 22'h060000;
  localparam logic [21:0] OBJ_SDRAM = 22'h080000;

  // active-low byte enables
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } prog_entry_t;

  localparam int unsigned ENTRY_W = $bits(prog_entry_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/jtdd2_dwnld_fifo.sv
// Show-ahead synchronous FIFO holding decoded SDRAM writes; a push on full is
// accepted only when a pop happens on the same edge.
module jtdd2_dwnld_fifo #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data_c,
  output logic          full_c,
  output logic          empty_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd     = rd_en && !empty_c;
  assign do_wr     = wr_en && (!full_c || do_rd);
  assign rd_data_c = mem[rd_ptr[AW-1:0]];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // read/write pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/jtdd2_dwnld.sv
// Double Dragon II download remapper: region decode, write queue, SDRAM
// handshake and PROM BRAM strobe.
module jtdd2_dwnld
  import jtdd2_dwnld_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_ack,
  output logic        prom_we,
  output logic [8:0]  prom_addr,
  output logic [7:0]  prom_data,
  output logic        dwnld_busy,
  output logic        overflow
);

  prog_entry_t dec;
  logic        dec_vld;
  logic        prom_hit;
  logic [16:0] off_zw, off_xy;
  logic [18:0] off_wz, off_oxy;
  logic [8:0]  off_prom;

  logic [ENTRY_W-1:0] fifo_rd_data_c;
  prog_entry_t        head;
  logic               fifo_full_c, fifo_empty_c, fifo_pop;

  wr_state_t   state, state_nxt;
  logic        prog_we_nxt;
  logic [21:0] prog_addr_nxt;
  logic [7:0]  prog_data_nxt;
  logic [1:0]  prog_mask_nxt;
  logic        dl_q;

  // offsets only need as many bits as the region, so subtract on the low bits
  assign off_zw   = ioctl_addr[16:0] - SCRZW_ADDR[16:0];
  assign off_xy   = ioctl_addr[16:0] - SCRXY_ADDR[16:0];
  assign off_wz   = ioctl_addr[18:0] - OBJWZ_ADDR[18:0];
  assign off_oxy  = ioctl_addr[18:0] - OBJXY_ADDR[18:0];
  assign off_prom = ioctl_addr[8:0]  - PROM_ADDR[8:0];

  // region decode of the incoming byte
  always_comb begin
    dec      = '0;
    dec.data = ioctl_data;
    dec.mask = MASK_NONE;
    dec_vld  = 1'b0;
    prom_hit = 1'b0;
    if (ioctl_addr < SCRZW_ADDR) begin
      dec.addr = {1'b0, ioctl_addr[21:1]};
      dec.mask = ioctl_addr[0] ? MASK_HI : MASK_LO;
      dec_vld  = ioctl_wr;
    end else if (ioctl_addr < SCRXY_ADDR) begin
      dec.addr = SCR_SDRAM + {5'd0, off_zw};
      dec.mask = MASK_LO;
      dec_vld  = ioctl_wr;
    end else if (ioctl_addr < OBJWZ_ADDR) begin
      dec.addr = SCR_SDRAM + {5'd0, off_xy};
      dec.mask = MASK_HI;
      dec_vld  = ioctl_wr;
    end else if (ioctl_addr < OBJXY_ADDR) begin
      dec.addr = OBJ_SDRAM + {3'd0, off_wz};
      dec.mask = MASK_LO;
      dec_vld  = ioctl_wr;
    end else if (ioctl_addr < PROM_ADDR) begin
      dec.addr = OBJ_SDRAM + {3'd0, off_oxy};
      dec.mask = MASK_HI;
      dec_vld  = ioctl_wr;
    end else if (ioctl_addr < PROM_END) begin
      prom_hit = ioctl_wr;
    end
  end

  // PROM bytes bypass the queue and strobe the BRAM for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      prom_we   <= 1'b0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= prom_hit;
      if (prom_hit) begin
        prom_addr <= off_prom;
        prom_data <= ioctl_data;
      end
    end
  end

  jtdd2_dwnld_fifo #(
    .AW (FIFO_AW),
    .DW (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (dec_vld),
    .wr_data   (dec),
    .rd_en     (fifo_pop),
    .rd_data_c (fifo_rd_data_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  assign head = prog_entry_t'(fifo_rd_data_c);

  // sticky overflow, cleared when a new download starts
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (downloading && !dl_q)                        overflow <= 1'b0;
      else if (dec_vld && fifo_full_c && !fifo_pop)    overflow <= 1'b1;
    end
  end

  // write FSM state and registered SDRAM request
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= MASK_NONE;
    end else begin
      state     <= state_nxt;
      prog_we   <= prog_we_nxt;
      prog_addr <= prog_addr_nxt;
      prog_data <= prog_data_nxt;
      prog_mask <= prog_mask_nxt;
    end
  end

  // next state: load from queue head in IDLE, hold request until ack
  always_comb begin
    state_nxt     = state;
    prog_we_nxt   = prog_we;
    prog_addr_nxt = prog_addr;
    prog_data_nxt = prog_data;
    prog_mask_nxt = prog_mask;
    fifo_pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          fifo_pop      = 1'b1;
          prog_addr_nxt = head.addr;
          prog_data_nxt = head.data;
          prog_mask_nxt = head.mask;
          prog_we_nxt   = 1'b1;
          state_nxt     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (prog_ack) begin
          prog_we_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dwnld_busy = downloading | ~fifo_empty_c | prog_we;

endmodule

// File: tb/tb_jtdd2_dwnld.sv
// Self-checking bench for jtdd2_dwnld: scoreboard of expected SDRAM writes.
module tb_jtdd2_dwnld;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack;
  logic        prom_we;
  logic [8:0]  prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_busy;
  logic        overflow;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] sb[$];

  jtdd2_dwnld #(.FIFO_AW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .prog_ack    (prog_ack),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // one-cycle ioctl strobe; returns just after the sampling edge
  task automatic send(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(posedge clk);
    #1 ioctl_wr = 1'b0;
  endtask

  function automatic logic [31:0] ent(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    return {a, d, m};
  endfunction

  // wait for a request, compare with scoreboard head, hold, ack; optionally
  // inject a byte in the idle cycle right after the ack edge
  task automatic service(input int hold, input logic inj,
                         input logic [21:0] ia, input logic [7:0] id);
    logic [31:0] e;
    int t;
    t = 0;
    while (!prog_we && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!prog_we) begin
      check("we_timeout", 32'(prog_we), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("prog_addr", 32'(prog_addr), 32'(e[31:10]));
    check("prog_data", 32'(prog_data), 32'(e[9:2]));
    check("prog_mask", 32'(prog_mask), 32'(e[1:0]));
    repeat (hold) begin
      @(negedge clk);
      check("hold_we", 32'(prog_we), 32'd1);
      check("hold_addr", 32'(prog_addr), 32'(e[31:10]));
    end
    @(negedge clk);
    prog_ack = 1'b1;
    @(posedge clk);
    #1 prog_ack = 1'b0;
    if (inj) begin
      ioctl_addr = ia;
      ioctl_data = id;
      ioctl_wr   = 1'b1;
    end
    @(negedge clk);
    check("we_drop", 32'(prog_we), 32'd0);
    if (inj) begin
      @(posedge clk);
      #1 ioctl_wr = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    ioctl_wr = 1'b0; prog_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_prog_we", 32'(prog_we), 32'd0);
    check("rst_prom_we", 32'(prom_we), 32'd0);
    check("rst_prog_addr", 32'(prog_addr), 32'd0);
    check("rst_prog_data", 32'(prog_data), 32'd0);
    check("rst_prog_mask", 32'(prog_mask), 32'd3);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(dwnld_busy), 32'd0);

    // 1: linear byte, latency n+2, held for 3 cycles before ack
    downloading = 1'b1;
    @(negedge clk);
    sb.push_back(ent(22'h000091, 8'h5A, 2'b01));
    send(22'h000123, 8'h5A);
    @(negedge clk);
    check("lat_n1_we", 32'(prog_we), 32'd0);
    @(negedge clk);
    check("lat_n2_we", 32'(prog_we), 32'd1);
    service(3, 1'b0, '0, '0);

    // 2: scroll halves share a word
    sb.push_back(ent(22'h060010, 8'h11, 2'b10));
    sb.push_back(ent(22'h060010, 8'h22, 2'b01));
    send(22'h090010, 8'h11);
    send(22'h0B0010, 8'h22);
    service(0, 1'b0, '0, '0);
    service(1, 1'b0, '0, '0);

    // 3: object XY half, first and last byte
    sb.push_back(ent(22'h080004, 8'h33, 2'b01));
    sb.push_back(ent(22'h0DFFFF, 8'h44, 2'b01));
    send(22'h130004, 8'h33);
    send(22'h18FFFF, 8'h44);
    service(0, 1'b0, '0, '0);
    service(0, 1'b0, '0, '0);

    // 4: PROM strobe, then a byte past the PROM that must vanish
    @(negedge clk);
    send(22'h190105, 8'h0C);
    @(negedge clk);
    check("prom_we_n1", 32'(prom_we), 32'd1);
    check("prom_addr", 32'(prom_addr), 32'h105);
    check("prom_data", 32'(prom_data), 32'h0C);
    @(negedge clk);
    check("prom_we_n2", 32'(prom_we), 32'd0);
    check("prom_no_prog", 32'(prog_we), 32'd0);
    send(22'h190200, 8'h77);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | prom_we | prog_we;
    end
    check("drop_no_output", 32'(seen), 32'd0);
    downloading = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(dwnld_busy), 32'd0);

    // 5: one write stuck in flight, then a 6-byte burst into a 4-deep queue
    downloading = 1'b1;
    sb.push_back(ent(22'h000008, 8'hA0, 2'b10));
    send(22'h000010, 8'hA0);
    @(negedge clk);
    @(negedge clk);
    check("b0_inflight", 32'(prog_we), 32'd1);
    sb.push_back(ent(22'h000010, 8'hB1, 2'b01));
    sb.push_back(ent(22'h060100, 8'hB2, 2'b10));
    sb.push_back(ent(22'h060101, 8'hB3, 2'b01));
    sb.push_back(ent(22'h080002, 8'hB4, 2'b10));
    send(22'h000021, 8'hB1);
    send(22'h090100, 8'hB2);
    send(22'h0B0101, 8'hB3);
    send(22'h0D0002, 8'hB4);
    send(22'h130003, 8'hB5);
    send(22'h000030, 8'hB6);
    @(negedge clk);
    check("overflow_set", 32'(overflow), 32'd1);
    downloading = 1'b0;
    // B7 pushed while full, on the same edge as B1 is popped
    sb.push_back(ent(22'h000020, 8'hB7, 2'b10));
    service(1, 1'b1, 22'h000040, 8'hB7);
    for (int i = 0; i < 4; i++) begin
      service(0, 1'b0, '0, '0);
      check("burst_busy", 32'(dwnld_busy), 32'd1);
    end
    service(0, 1'b0, '0, '0);
    check("busy_after_last", 32'(dwnld_busy), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | prog_we;
    end
    check("no_b5_b6", 32'(seen), 32'd0);
    downloading = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("overflow_clear", 32'(overflow), 32'd0);

    // 6: reset with a write in flight and two entries queued
    send(22'h000050, 8'hC0);
    send(22'h000051, 8'hC1);
    send(22'h000052, 8'hC2);
    @(negedge clk);
    check("pre_rst_we", 32'(prog_we), 32'd1);
    downloading = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst6_we", 32'(prog_we), 32'd0);
    check("rst6_mask", 32'(prog_mask), 32'd3);
    check("rst6_busy", 32'(dwnld_busy), 32'(downloading));
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | prog_we | dwnld_busy;
    end
    check("rst6_queue_empty", 32'(seen), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
